cpu_clkgen: RTL and testbench

Parametrised CPU/peripheral clock-enable generator. Produces complementary CPU phase enables (`ce_p`/`ce_n`) from `clk_sys` at one of N selectable divider rates. Supports per-period wait stalls (memory/IO contention), with a per-mode wait mask. Mode changes are glitch-free: the current period drains, then a quiet gap is inserted before the new rate starts. Also produces N_AUX free-running enables for sound chips and FDC. Sits between the PLL and the T80 core, PSGs and FDC in the top level.

---
 rtl/cpu_clkgen_pkg.sv | 14 +
 rtl/ce_divider.sv | 27 ++
 rtl/cpu_clkgen.sv | 115 +++++++++++
 tb/tb_cpu_clkgen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_clkgen_pkg.sv
// Shared types and defaults for the CPU/peripheral clock-enable generator.
package cpu_clkgen_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, GAP} clkgen_state_t;

    localparam logic [15:0] DIVIDERS_DEF = {8'd27, 8'd16};
    localparam logic [15:0] AUX_DIVS_DEF = {8'd54, 8'd12};

    // Dividers below 2 would make ce_p and ce_n collide, so floor them at 2.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'd2) ? 32'd2 : d;
    endfunction

endpackage

// File: rtl/ce_divider.sv
// Free-running one-clock-wide enable every DIV clocks; first pulse right after reset.
module ce_divider
    import cpu_clkgen_pkg::*;
#(
    parameter int               DIV_W = 8,
    parameter logic [DIV_W-1:0] DIV   = 2
) (
    input  logic clk_sys,
    input  logic reset,
    output logic ce
);

    localparam logic [DIV_W-1:0] D = DIV_W'(clamp_div(32'(DIV)));

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else begin
            ce  <= (cnt == '0);
            cnt <= (cnt == D - 1'b1) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_clkgen.sv
// CPU phase-enable generator with per-mode dividers, wait stalls and glitch-free
// mode switching (drain, quiet gap, restart), plus free-running aux enables.
module cpu_clkgen
    import cpu_clkgen_pkg::*;
#(
    parameter int                        N_MODES    = 2,
    parameter int                        DIV_W      = 8,
    parameter logic [N_MODES*DIV_W-1:0]  DIVIDERS   = DIVIDERS_DEF,
    parameter logic [N_MODES-1:0]        WAIT_MASK  = 2'b10,
    parameter int                        RESET_MODE = 0,
    parameter int                        GAP_CYCLES = 48,
    parameter int                        N_AUX      = 2,
    parameter logic [N_AUX*DIV_W-1:0]    AUX_DIVS   = AUX_DIVS_DEF
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic [$clog2(N_MODES)-1:0] mode_req,
    input  logic                       wait_req,
    output logic                       ce_p,
    output logic                       ce_n,
    output logic [N_AUX-1:0]           ce_aux,
    output logic [$clog2(N_MODES)-1:0] mode_act,
    output logic                       switching
);

    localparam int MW = $clog2(N_MODES);

    logic [N_MODES-1:0][DIV_W-1:0] div_tab;

    for (genvar m = 0; m < N_MODES; m++) begin : g_div
        assign div_tab[m] = DIV_W'(clamp_div(32'(DIVIDERS[m*DIV_W +: DIV_W])));
    end

    for (genvar k = 0; k < N_AUX; k++) begin : g_aux
        ce_divider #(
            .DIV_W (DIV_W),
            .DIV   (AUX_DIVS[k*DIV_W +: DIV_W])
        ) u_aux (
            .clk_sys (clk_sys),
            .reset   (reset),
            .ce      (ce_aux[k])
        );
    end

    clkgen_state_t    state, state_nx;
    logic [DIV_W-1:0] cnt, gap_cnt;
    logic [MW-1:0]    target;
    logic             stall;

    logic [DIV_W-1:0] d_cur, half;
    logic             period_end, gap_end, stall_now;

    assign d_cur      = div_tab[mode_act];
    assign half       = d_cur >> 1;
    assign period_end = (cnt == d_cur - 1'b1);
    assign gap_end    = (gap_cnt == DIV_W'(GAP_CYCLES - 1));
    assign stall_now  = wait_req & ~WAIT_MASK[mode_act];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (mode_req != mode_act) state_nx = DRAIN;
            DRAIN:   if (period_end) state_nx = (mode_req == mode_act) ? RUN : GAP;
            GAP:     if (mode_req == target && gap_end) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            gap_cnt   <= '0;
            stall     <= 1'b0;
            target    <= MW'(RESET_MODE);
            mode_act  <= MW'(RESET_MODE);
            ce_p      <= 1'b0;
            ce_n      <= 1'b0;
            switching <= 1'b0;
        end else begin
            switching <= (state_nx != RUN);
            ce_p      <= 1'b0;
            ce_n      <= 1'b0;
            if (state == GAP) begin
                // Counter parks at 0 so the new mode starts on a clean period.
                cnt <= '0;
                if (mode_req != target) begin
                    target  <= mode_req;
                    gap_cnt <= '0;
                end else if (gap_end) begin
                    mode_act <= target;
                    gap_cnt  <= '0;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end else begin
                cnt <= period_end ? '0 : cnt + 1'b1;
                if (cnt == '0) begin
                    stall <= stall_now;
                    ce_p  <= ~stall_now;
                end
                if (cnt == half) ce_n <= ~stall;
                if (state == DRAIN && period_end) begin
                    target  <= mode_req;
                    gap_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_clkgen.sv
// Directed + random stimulus for cpu_clkgen against a cycle-accurate behavioural model.
module tb_cpu_clkgen;

    localparam int GAPC = 48;
    localparam int DIVS [2] = '{16, 27};
    localparam int MASK [2] = '{0, 1};
    localparam int AUXD [2] = '{12, 54};

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic [0:0] mode_req = 1'b0;
    logic       wait_req = 1'b0;
    logic       ce_p, ce_n, switching;
    logic [1:0] ce_aux;
    logic [0:0] mode_act;

    cpu_clkgen #(
        .N_MODES    (2),
        .DIV_W      (8),
        .DIVIDERS   ({8'd27, 8'd16}),
        .WAIT_MASK  (2'b10),
        .RESET_MODE (0),
        .GAP_CYCLES (GAPC),
        .N_AUX      (2),
        .AUX_DIVS   ({8'd54, 8'd12})
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .mode_req  (mode_req),
        .wait_req  (wait_req),
        .ce_p      (ce_p),
        .ce_n      (ce_n),
        .ce_aux    (ce_aux),
        .mode_act  (mode_act),
        .switching (switching)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Model: phase derived from elapsed clocks since the current mode's anchor.
    int t, anchor, mst, act, tgt, g;
    bit stl, e_p, e_n, e_sw;
    logic [1:0] e_aux;

    function automatic int phase_now();
        return (t - anchor) % DIVS[act];
    endfunction

    task automatic model_reset();
        t = 0; anchor = 0; mst = 0; act = 0; tgt = 0; g = 0;
        stl = 0; e_p = 0; e_n = 0; e_sw = 0; e_aux = '0;
    endtask

    task automatic model_edge();
        int d, ph;
        if (reset) begin
            model_reset();
            return;
        end
        d = DIVS[act];
        ph = (t - anchor) % d;
        e_p = 0;
        e_n = 0;
        if (mst != 2) begin
            if (ph == 0) begin
                stl = wait_req && (MASK[act] == 0);
                e_p = !stl;
            end
            if (ph == d / 2) e_n = !stl;
            if (mst == 0 && int'(mode_req) != act) mst = 1;
            else if (mst == 1 && ph == d - 1) begin
                if (int'(mode_req) == act) mst = 0;
                else begin tgt = int'(mode_req); g = 0; mst = 2; end
            end
        end else begin
            if (int'(mode_req) != tgt) begin tgt = int'(mode_req); g = 0; end
            else if (g == GAPC - 1) begin act = tgt; mst = 0; anchor = t + 1; end
            else g++;
        end
        for (int k = 0; k < 2; k++) e_aux[k] = ((t % AUXD[k]) == 0);
        t++;
        e_sw = (mst != 0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0d", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("ce_p", 32'(ce_p), 32'(e_p));
        chk("ce_n", 32'(ce_n), 32'(e_n));
        chk("ce_aux", 32'(ce_aux), 32'(e_aux));
        chk("mode_act", 32'(mode_act), 32'(act));
        chk("switching", 32'(switching), 32'(e_sw));
    endtask

    task automatic cycle();
        @(posedge clk_sys);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advance until the next edge lands on the requested phase outside GAP.
    task automatic sync_phase(input int ph);
        int i;
        for (i = 0; i < 300 && !(mst != 2 && phase_now() == ph); i++) cycle();
        chk("sync_phase_timeout", 32'(i < 300), 32'd1);
    endtask

    task automatic wait_gap();
        int i;
        for (i = 0; i < 300 && mst != 2; i++) cycle();
        chk("wait_gap_timeout", 32'(mst), 32'd2);
    endtask

    task automatic wait_pulse_test();
        sync_phase(0);
        run(2 * DIVS[act]);
        wait_req = 1'b1;
        cycle();
        wait_req = 1'b0;
        run(3 * DIVS[act]);
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        run(3);
        reset = 1'b0;

        run(64);
        wait_pulse_test();

        // Switch 0 -> 1 mid-period, then exercise the masked wait in mode 1.
        sync_phase(5);
        mode_req = 1'b1;
        run(16 + GAPC + 27 * 3);
        wait_pulse_test();

        // Back to mode 0, then a change that reverts within the drain period.
        sync_phase(5);
        mode_req = 1'b0;
        run(27 + GAPC + 40);
        sync_phase(3);
        mode_req = 1'b1;
        run(4);
        mode_req = 1'b0;
        run(40);

        // Request changes again 20 clocks into the gap.
        mode_req = 1'b1;
        wait_gap();
        run(20);
        mode_req = 1'b0;
        run(GAPC + 40);

        // Asynchronous reset in the middle of a gap.
        mode_req = 1'b1;
        wait_gap();
        run(10);
        reset = 1'b1;
        mode_req = 1'b0;
        #1;
        model_reset();
        check_all();
        run(2);
        reset = 1'b0;
        run(120);

        // Random traffic: sparse mode changes, frequent wait requests.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(63) == 0) mode_req = 1'($urandom_range(1));
            wait_req = ($urandom_range(3) == 0);
            cycle();
        end
        wait_req = 1'b0;
        run(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
